// File: rtl/uart_rx_depacketizer.sv
// uart_rx_depacketizer: 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through byte buffer
module uart_rx_depacketizer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    serial_in,
  input  logic                    rx_ready,
  output logic [7:0]              rx_data,
  output logic                    rx_valid,
  output logic                    frame_err,
  output logic                    overrun,
  output logic                    rx_busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] TICK_MAX = 16'(CLK_FREQ / (BAUD_RATE * OVERSAMPLE) - 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic s0, s1, s2;
  logic [15:0] baud_cnt;
  logic [3:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] shift;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic tick, fall, stop_pt, push, pop, wr;
  assign tick = baud_cnt == TICK_MAX;
  assign fall = s2 & ~s1;
  assign stop_pt = state == STOP && tick && tcnt == 4'd15;
  assign push = stop_pt & s1;
  assign pop = rx_valid & rx_ready;
  // a full buffer still accepts a byte when the head leaves in the same cycle
  assign wr = push & (fifo_count != FULL | pop);
  assign rx_valid = fifo_count != '0;
  assign rx_data = rx_valid ? mem[rp] : 8'h00;
  assign rx_busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      s2 <= 1'b1;
      baud_cnt <= '0;
    end else begin
      s0 <= serial_in;
      s1 <= s0;
      s2 <= s1;
      baud_cnt <= tick ? '0 : baud_cnt + 16'd1;
    end
  end
  // tcnt and bcnt wrap naturally at 16 ticks per bit and 8 bits per byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tcnt <= '0;
      bcnt <= '0;
      shift <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_pt & ~s1;
      case (state)
        IDLE: if (fall) begin
          tcnt <= '0;
          state <= START;
        end
        START: if (tick) begin
          if (tcnt == 4'd7) begin
            tcnt <= '0;
            bcnt <= '0;
            state <= s1 ? IDLE : DATA;
          end else tcnt <= tcnt + 4'd1;
        end
        DATA: if (tick) begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            shift <= {s1, shift[7:1]};
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= STOP;
          end
        end
        STOP: if (tick) begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd15) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= shift;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push & ~wr;
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      fifo_count <= fifo_count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_uart_rx_depacketizer.sv
// tb_uart_rx_depacketizer: directed frames against a queue-based scoreboard of the receiver and buffer
module tb_uart_rx_depacketizer;
  localparam int DEPTH = 4;
  // 3 cycles sync+edge detect, 8 ticks to start midpoint, 9 bits of 16 to stop midpoint
  localparam int LAT = 3 + 8 + 16 * 9;
  logic clk = 0, rst = 1, serial_in = 1, rx_ready = 0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, rx_busy;
  logic [2:0] fifo_count;
  uart_rx_depacketizer #(.CLK_FREQ(1600), .BAUD_RATE(100), .OVERSAMPLE(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .rx_busy(rx_busy), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] q[$];
  logic [7:0] popped[$];
  int ev_cyc = 0, busy_lo = 0, busy_hi = 0;
  bit ev_on = 0, ev_good = 0, exp_ferr = 0, exp_ovr = 0, armed = 0;
  logic [7:0] ev_data = 0;
  int vcnt = 0, fcnt = 0, ocnt = 0;
  logic [7:0] last = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin : model
    bit pop_m, full_m, hit;
    cyc++;
    exp_ferr = 0;
    exp_ovr = 0;
    armed = 1;
    if (rst) begin
      q.delete();
      ev_on = 0;
      busy_hi = 0;
    end else begin
      pop_m = q.size() != 0 && rx_ready;
      full_m = q.size() == DEPTH;
      hit = ev_on && cyc == ev_cyc;
      if (pop_m) void'(q.pop_front());
      if (hit) begin
        ev_on = 0;
        if (!ev_good) exp_ferr = 1;
        else if (!full_m || pop_m) q.push_back(ev_data);
        else exp_ovr = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("valid", rx_valid, q.size() != 0);
      chk("count", fifo_count, q.size());
      if (q.size() != 0) chk("data", rx_data, q[0]);
      chk("frame_err", frame_err, exp_ferr);
      chk("overrun", overrun, exp_ovr);
      chk("busy", rx_busy, cyc >= busy_lo && cyc < busy_hi);
      if (rx_valid) begin vcnt++; last = rx_data; end
      if (frame_err) fcnt++;
      if (overrun) ocnt++;
      if (rx_valid && rx_ready) popped.push_back(rx_data);
    end
  end
  task automatic clr();
    vcnt = 0; fcnt = 0; ocnt = 0; last = 0;
    popped.delete();
  endtask
  task automatic idle(input int n);
    serial_in = 1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  // drives start, 8 data bits LSB first and stop; cut<160 abandons the frame early
  task automatic drive_frame(input logic [7:0] d, input bit stop, input int cut, input int rdy_c);
    @(posedge clk); #1;
    ev_cyc = cyc + LAT; ev_data = d; ev_good = stop; ev_on = 1;
    busy_lo = cyc + 3; busy_hi = cyc + LAT;
    for (int c = 0; c < 160 && c < cut; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      serial_in = c < 16 ? 1'b0 : c < 144 ? d[(c - 16) / 16] : stop;
      if (rdy_c >= 0) rx_ready = (c == rdy_c);
    end
  endtask
  task automatic glitch();
    @(posedge clk); #1;
    busy_lo = cyc + 3; busy_hi = cyc + 11;
    serial_in = 0;
    repeat (4) @(posedge clk);
    #1 serial_in = 1;
  endtask
  task automatic chk_pops(input logic [7:0] a, b, c, d);
    logic [7:0] e[4];
    e = '{a, b, c, d};
    chk("pop_n", popped.size(), 4);
    for (int i = 0; i < 4; i++) chk("pop_order", i < popped.size() ? 32'(popped[i]) : 32'hdead, e[i]);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    idle(5);
    rx_ready = 1; clr();
    drive_frame(8'hA5, 1, 160, -1);
    idle(20);
    chk("a5_vcnt", vcnt, 1);
    chk("a5_data", last, 8'hA5);
    chk("a5_ferr", fcnt, 0);
    chk("a5_ovr", ocnt, 0);
    clr();
    drive_frame(8'h3C, 0, 160, -1);
    idle(20);
    chk("3c_ferr", fcnt, 1);
    chk("3c_vcnt", vcnt, 0);
    chk("3c_count", fifo_count, 0);
    clr();
    glitch();
    idle(20);
    chk("gl_busy", rx_busy, 0);
    chk("gl_vcnt", vcnt, 0);
    chk("gl_err", fcnt + ocnt, 0);
    rx_ready = 0; clr();
    for (int i = 1; i <= 5; i++) drive_frame(8'(i), 1, 160, -1);
    idle(5);
    chk("fill_count", fifo_count, 4);
    chk("fill_ovr", ocnt, 1);
    popped.delete();
    rx_ready = 1;
    idle(8);
    rx_ready = 0;
    chk_pops(8'h01, 8'h02, 8'h03, 8'h04);
    foreach (popped[i]) ;
    drive_frame(8'h11, 1, 160, -1);
    drive_frame(8'h22, 1, 160, -1);
    drive_frame(8'h33, 1, 160, -1);
    drive_frame(8'h44, 1, 160, -1);
    clr();
    drive_frame(8'h77, 1, 160, LAT - 1);
    idle(3);
    chk("full_pop_ovr", ocnt, 0);
    chk("full_pop_count", fifo_count, 4);
    popped.delete();
    rx_ready = 1;
    idle(8);
    rx_ready = 0;
    chk_pops(8'h22, 8'h33, 8'h44, 8'h77);
    drive_frame(8'h11, 1, 160, -1);
    drive_frame(8'h22, 1, 160, -1);
    drive_frame(8'h5A, 1, 70, -1);
    chk("pre_rst_busy", rx_busy, 1);
    rst = 1; serial_in = 1;
    @(posedge clk); #1;
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", rx_busy, 0);
    rst = 0;
    idle(5);
    rx_ready = 1; clr();
    drive_frame(8'h81, 1, 160, -1);
    idle(20);
    chk("81_vcnt", vcnt, 1);
    chk("81_data", last, 8'h81);
    chk("81_ferr", fcnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
